// File: rtl/game_control.sv
// game_control: top-level gameplay FSM. Turns player keys into one datapath
// command at a time, waits for the matching *_done pulse, paces actions with a
// frame-rate divider and forces a full redraw after every action.
// Optional build macro: CTRL_TIMEOUT_EN adds a per-command watchdog that
// returns to S_INIT and pulses timeout_err when a done never arrives.
module game_control #(
   parameter int RATE_DIV       = 833333,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_attack,
   input  logic       init_done,
   input  logic       idle_done,
   input  logic       attack_done,
   input  logic       move_done,
   input  logic       draw_done,
   output logic       init,
   output logic       idle,
   output logic       attack,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic       draw,
   output logic [1:0] facing,
   output logic       timeout_err
);

   localparam int DIV_W = $clog2(RATE_DIV);

   // Elaboration-time sanity checks on the configuration.
   if (RATE_DIV < 2) begin : g_bad_rate
      $error("game_control: RATE_DIV must be >= 2");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("game_control: TIMEOUT_CYCLES must be >= 2");
   end

   typedef enum logic [3:0] {
      S_INIT,
      S_DRAW,
      S_WAIT,
      S_ATTACK,
      S_UP,
      S_DOWN,
      S_LEFT,
      S_RIGHT,
      S_IDLE
   } state_t;

   state_t             r_state;
   state_t             w_next;
   state_t             w_dispatch;
   logic [DIV_W-1:0]   r_div;
   logic               w_tick;
   logic [1:0]         r_facing;
   logic               r_attack_latch;
   logic               r_attack_prev;
   logic               w_attack_rise;
   logic               w_done;
   logic               w_timeout;

`ifdef CTRL_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);
   logic [TO_W-1:0]    r_to_cnt;
   logic               r_timeout_err;
`endif

   assign w_tick        = (r_div == DIV_W'(RATE_DIV - 1));
   assign w_attack_rise = key_attack & ~r_attack_prev;

   // Free-running action-slot divider; wraps at RATE_DIV-1 and flags the tick.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_div <= '0;
      end else if (w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   // Select the done pulse that belongs to the current command state.
   always_comb begin
      w_done = 1'b0;
      case (r_state)
         S_INIT:                       w_done = init_done;
         S_DRAW:                       w_done = draw_done;
         S_ATTACK:                     w_done = attack_done;
         S_UP, S_DOWN, S_LEFT, S_RIGHT: w_done = move_done;
         S_IDLE:                       w_done = idle_done;
         default:                      w_done = 1'b0;
      endcase
   end

   // Action priority at a tick: pending attack, then up/down/left/right, else idle.
   always_comb begin
      w_dispatch = S_IDLE;
      if (r_attack_latch)  w_dispatch = S_ATTACK;
      else if (key_up)     w_dispatch = S_UP;
      else if (key_down)   w_dispatch = S_DOWN;
      else if (key_left)   w_dispatch = S_LEFT;
      else if (key_right)  w_dispatch = S_RIGHT;
   end

   // Watchdog expiry: stuck in a command state for the full timeout window.
`ifdef CTRL_TIMEOUT_EN
   assign w_timeout = (r_state != S_WAIT) && !w_done &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // Next-state: every finished command returns to a redraw; a redraw returns to wait.
   always_comb begin
      w_next = r_state;
      if (w_timeout) begin
         w_next = S_INIT;
      end else if (r_state == S_WAIT) begin
         if (w_tick) w_next = w_dispatch;
      end else if (w_done) begin
         w_next = (r_state == S_DRAW) ? S_WAIT : S_DRAW;
      end
   end

   // State register plus facing, attack latch and watchdog bookkeeping.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= S_INIT;
         r_facing       <= 2'd1;
         r_attack_latch <= 1'b0;
         r_attack_prev  <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
         r_to_cnt       <= '0;
         r_timeout_err  <= 1'b0;
`endif
      end else begin
         r_state       <= w_next;
         r_attack_prev <= key_attack;

         if (r_state == S_WAIT) begin
            case (w_next)
               S_UP:    r_facing <= 2'd0;
               S_DOWN:  r_facing <= 2'd1;
               S_LEFT:  r_facing <= 2'd2;
               S_RIGHT: r_facing <= 2'd3;
               default: r_facing <= r_facing;
            endcase
         end

         // A fresh press wins over the clear from entering S_ATTACK.
         if (w_attack_rise) begin
            r_attack_latch <= 1'b1;
         end else if ((w_next == S_ATTACK) && (r_state != S_ATTACK)) begin
            r_attack_latch <= 1'b0;
         end

`ifdef CTRL_TIMEOUT_EN
         r_timeout_err <= w_timeout;
         if (w_timeout || (w_next != r_state)) begin
            r_to_cnt <= '0;
         end else if (r_state != S_WAIT) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end
`endif
      end
   end

   // Moore command decode; reset blanks all commands in the same cycle.
   always_comb begin
      init   = !reset && (r_state == S_INIT);
      idle   = !reset && (r_state == S_IDLE);
      attack = !reset && (r_state == S_ATTACK);
      up     = !reset && (r_state == S_UP);
      down   = !reset && (r_state == S_DOWN);
      left   = !reset && (r_state == S_LEFT);
      right  = !reset && (r_state == S_RIGHT);
      draw   = !reset && (r_state == S_DRAW);
   end

   assign facing = r_facing;

`ifdef CTRL_TIMEOUT_EN
   assign timeout_err = r_timeout_err;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_game_control.sv
// Directed self-checking bench for game_control (RATE_DIV=4, TIMEOUT_CYCLES=8).
// Command vector bit order: 7 init, 6 idle, 5 attack, 4 up, 3 down, 2 left, 1 right, 0 draw.
module tb_game_control;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
   logic       key_attack = 1'b0;
   logic       init_done = 1'b0, idle_done = 1'b0, attack_done = 1'b0;
   logic       move_done = 1'b0, draw_done = 1'b0;
   logic       init, idle, attack, up, down, left, right, draw;
   logic [1:0] facing;
   logic       timeout_err;
   logic [7:0] cmds;

   int errs   = 0;
   int checks = 0;
   logic [1:0] prev_f = 2'd1;

   localparam logic [7:0] C_NONE   = 8'h00;
   localparam logic [7:0] C_INIT   = 8'h80;
   localparam logic [7:0] C_IDLE   = 8'h40;
   localparam logic [7:0] C_ATTACK = 8'h20;
   localparam logic [7:0] C_UP     = 8'h10;
   localparam logic [7:0] C_RIGHT  = 8'h02;
   localparam logic [7:0] C_DRAW   = 8'h01;

   game_control #(.RATE_DIV(4), .TIMEOUT_CYCLES(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .key_up      (key_up),
      .key_down    (key_down),
      .key_left    (key_left),
      .key_right   (key_right),
      .key_attack  (key_attack),
      .init_done   (init_done),
      .idle_done   (idle_done),
      .attack_done (attack_done),
      .move_done   (move_done),
      .draw_done   (draw_done),
      .init        (init),
      .idle        (idle),
      .attack      (attack),
      .up          (up),
      .down        (down),
      .left        (left),
      .right       (right),
      .draw        (draw),
      .facing      (facing),
      .timeout_err (timeout_err)
   );

   assign cmds = {init, idle, attack, up, down, left, right, draw};

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Wait (no responses) until any command asserts.
   task automatic wait_any(input string tag, input int max);
      int n;
      n = 0;
      while (cmds == 8'h00 && n < max) begin
         step();
         n++;
      end
      check(tag, {31'd0, cmds != 8'h00}, 32'd1);
   endtask

   // Answer every active command with its done until the target bit asserts.
   task automatic respond_until(input string tag, input int idx, input int max);
      int n;
      n = 0;
      while (!cmds[idx] && n < max) begin
         init_done = init; idle_done = idle; attack_done = attack;
         move_done = up | down | left | right; draw_done = draw;
         step();
         init_done = 0; idle_done = 0; attack_done = 0; move_done = 0; draw_done = 0;
         n++;
      end
      check(tag, {31'd0, cmds[idx]}, 32'd1);
   endtask

   // Auto-responder for n cycles; counts attacks and moves, checks attack keeps facing.
   task automatic run_auto(input int n, inout int atk, inout int mv);
      for (int i = 0; i < n; i++) begin
         if (attack) begin
            atk++;
            check("attack_keeps_facing", {30'd0, facing}, {30'd0, prev_f});
         end
         if (up | down | left | right) mv++;
         init_done = init; idle_done = idle; attack_done = attack;
         move_done = up | down | left | right; draw_done = draw;
         prev_f = facing;
         step();
         init_done = 0; idle_done = 0; attack_done = 0; move_done = 0; draw_done = 0;
      end
   endtask

   initial begin
      int atk;
      int mv;
      int n;
      int bad;
      atk = 0;
      mv  = 0;

      // Reset held two cycles.
      step();
      step();
      check("reset_cmds", {24'd0, cmds}, {24'd0, C_NONE});
      check("reset_facing", {30'd0, facing}, 32'd1);
      check("reset_timeout_err", {31'd0, timeout_err}, 32'd0);

      // Release: init immediately, draw after init_done.
      reset = 0;
      #1;
      check("init_after_release", {24'd0, cmds}, {24'd0, C_INIT});
      step();
      check("init_held", {24'd0, cmds}, {24'd0, C_INIT});
      init_done = 1; step(); init_done = 0;
      check("draw_after_init", {24'd0, cmds}, {24'd0, C_DRAW});

      // Held right: wait state until tick, then right with facing 3.
      key_right = 1;
      draw_done = 1; step(); draw_done = 0;
      check("wait_no_cmd", {24'd0, cmds}, {24'd0, C_NONE});
      wait_any("wait_right", 10);
      check("right_cmd", {24'd0, cmds}, {24'd0, C_RIGHT});
      check("facing_right", {30'd0, facing}, 32'd3);
      move_done = 1; step(); move_done = 0;
      check("draw_after_right", {24'd0, cmds}, {24'd0, C_DRAW});
      move_done = 1; step(); move_done = 0;
      check("stray_move_done", {24'd0, cmds}, {24'd0, C_DRAW});

      // Up, down and left together: up wins.
      key_right = 0; key_up = 1; key_down = 1; key_left = 1;
      draw_done = 1; step(); draw_done = 0;
      wait_any("wait_up", 10);
      check("up_priority", {24'd0, cmds}, {24'd0, C_UP});
      check("facing_up", {30'd0, facing}, 32'd0);
      move_done = 1; step(); move_done = 0;
      check("draw_after_up", {24'd0, cmds}, {24'd0, C_DRAW});

      // No keys: idle, then redraw.
      key_up = 0; key_down = 0; key_left = 0;
      draw_done = 1; step(); draw_done = 0;
      wait_any("wait_idle", 10);
      check("idle_cmd", {24'd0, cmds}, {24'd0, C_IDLE});
      idle_done = 1; step(); idle_done = 0;
      check("draw_after_idle", {24'd0, cmds}, {24'd0, C_DRAW});
      draw_done = 1; step(); draw_done = 0;

      // Attack held 40 cycles alongside left: one attack, left moves around it.
      key_left = 1; key_attack = 1;
      prev_f = facing;
      run_auto(40, atk, mv);
      check("one_attack_held", atk, 32'd1);
      check("moves_follow_left", {31'd0, mv > 0}, 32'd1);
      check("facing_left", {30'd0, facing}, 32'd2);
      key_attack = 0;
      run_auto(6, atk, mv);
      key_attack = 1;
      run_auto(20, atk, mv);
      check("second_attack", atk, 32'd2);
      key_attack = 0; key_left = 0;

      // Reset while up is active.
      key_up = 1;
      respond_until("reach_up", 4, 40);
      reset = 1;
      #1;
      check("reset_kills_up", {24'd0, cmds}, {24'd0, C_NONE});
      step();
      check("in_reset_cmds", {24'd0, cmds}, {24'd0, C_NONE});
      check("in_reset_facing", {30'd0, facing}, 32'd1);
      key_up = 0;
      reset = 0;
      #1;
      check("init_after_midreset", {24'd0, cmds}, {24'd0, C_INIT});
      init_done = 1; step(); init_done = 0;
      check("draw_before_timeout", {24'd0, cmds}, {24'd0, C_DRAW});

`ifdef CTRL_TIMEOUT_EN
      // Withhold draw_done: back to init after 8 cycles with one error pulse.
      n = 0;
      bad = 0;
      while (!init && n < 20) begin
         step();
         n++;
         if (!init && timeout_err) bad++;
      end
      check("timeout_cycles", n, 32'd8);
      check("timeout_err_pulse", {31'd0, timeout_err}, 32'd1);
      check("no_early_err", bad, 32'd0);
      step();
      check("timeout_err_one_cycle", {31'd0, timeout_err}, 32'd0);
      check("facing_kept", {30'd0, facing}, 32'd1);
`else
      // Without the watchdog, draw waits indefinitely and no error is raised.
      n = 0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         n++;
         if (cmds != C_DRAW || timeout_err) bad++;
      end
      check("draw_waits_forever", bad, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
